// File: rtl/svc_uart_rx.sv
// 8N1 UART receiver: 2-flop synchronized line, mid-bit sampling, single-byte
// valid/ready output buffer with overrun and framing-error pulses.
module svc_uart_rx #(
  parameter int CLOCK_FREQ = 25_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       urx_pin,
  output logic       urx_valid,
  output logic [7:0] urx_data,
  input  logic       urx_ready,
  output logic       urx_frame_err,
  output logic       urx_overrun
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [2:0]       bit_idx_r;
  logic [7:0]       shift_r;
  logic             sync1_r;
  logic             rx_r;
  logic             valid_r;
  logic [7:0]       data_r;
  logic             frame_err_r;
  logic             overrun_r;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b1;
      rx_r    <= 1'b1;
    end else begin
      sync1_r <= urx_pin;
      rx_r    <= sync1_r;
    end
  end

  // Receive FSM plus output buffer; error pulses default low every cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      bit_idx_r   <= 3'd0;
      shift_r     <= 8'h00;
      valid_r     <= 1'b0;
      data_r      <= 8'h00;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      // Drain on handshake; a delivery later in this block overrides it.
      if (valid_r && urx_ready) begin
        valid_r <= 1'b0;
      end
      case (state_r)
        ST_IDLE: begin
          if (!rx_r) begin
            state_r   <= ST_START;
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
          end
        end
        ST_START: begin
          if (cnt_r == HALF_LAST) begin
            cnt_r   <= '0;
            state_r <= rx_r ? ST_IDLE : ST_DATA;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r   <= '0;
            shift_r <= {rx_r, shift_r[7:1]};
            if (bit_idx_r == 3'd7) begin
              state_r <= ST_STOP;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (cnt_r == BIT_LAST) begin
            cnt_r <= '0;
            if (rx_r) begin
              state_r <= ST_IDLE;
              if (!valid_r || urx_ready) begin
                data_r  <= shift_r;
                valid_r <= 1'b1;
              end else begin
                overrun_r <= 1'b1;
              end
            end else begin
              frame_err_r <= 1'b1;
              state_r     <= ST_WAIT_IDLE;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_WAIT_IDLE: begin
          // A held-low (break) line must return high before a new start is armed.
          if (rx_r) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign urx_valid     = valid_r;
  assign urx_data      = data_r;
  assign urx_frame_err = frame_err_r;
  assign urx_overrun   = overrun_r;

endmodule

// File: tb/tb_svc_uart_rx.sv
// Directed self-checking bench for svc_uart_rx at default parameters.
module tb_svc_uart_rx;

  localparam int BIT = 217;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       urx_pin = 1'b1;
  logic       urx_valid;
  logic [7:0] urx_data;
  logic       urx_ready = 1'b0;
  logic       urx_frame_err;
  logic       urx_overrun;

  int tests = 0;
  int fails = 0;

  int         cyc = 0;
  logic [7:0] got_q[$];
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         vhi_cnt = 0;
  int         rise_cyc = 0;
  logic       prev_valid = 1'b0;

  svc_uart_rx dut (
    .clk           (clk),
    .rst           (rst),
    .urx_pin       (urx_pin),
    .urx_valid     (urx_valid),
    .urx_data      (urx_data),
    .urx_ready     (urx_ready),
    .urx_frame_err (urx_frame_err),
    .urx_overrun   (urx_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (urx_valid && urx_ready) got_q.push_back(urx_data);
    if (urx_frame_err) fe_cnt <= fe_cnt + 1;
    if (urx_overrun) ov_cnt <= ov_cnt + 1;
    if (urx_valid) vhi_cnt <= vhi_cnt + 1;
    if (urx_valid && !prev_valid) rise_cyc <= cyc;
    prev_valid <= urx_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    urx_pin = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      urx_pin = b[i];
      idle(BIT);
    end
    urx_pin = stop_bit;
    idle(BIT);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] got_at(input int idx);
    logic [7:0] v;
    v = 8'hxx;
    if (got_q.size() > idx) v = got_q[idx];
    return v;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    tests++; if (urx_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", urx_valid); end
    tests++; if (urx_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h expected 00", urx_data); end
    tests++; if (urx_frame_err !== 1'b0) begin fails++; $display("FAIL reset_fe: got %b expected 0", urx_frame_err); end
    tests++; if (urx_overrun !== 1'b0) begin fails++; $display("FAIL reset_ov: got %b expected 0", urx_overrun); end
    rst = 1'b0;
    idle(5);
  endtask

  task automatic test_single();
    int base, fe0, ov0, vh0, p;
    urx_ready = 1'b1;
    base = got_q.size(); fe0 = fe_cnt; ov0 = ov_cnt; vh0 = vhi_cnt;
    p = cyc;
    send_byte(8'h55, 1'b1);
    idle(20);
    tests++; if (got_q.size() !== base + 1) begin fails++; $display("FAIL single_count: got %0d expected %0d", got_q.size(), base + 1); end
    tests++; if (got_at(base) !== 8'h55) begin fails++; $display("FAIL single_data: got %h expected 55", got_at(base)); end
    tests++; if (vhi_cnt - vh0 !== 1) begin fails++; $display("FAIL single_valid_len: got %0d expected 1", vhi_cnt - vh0); end
    tests++; if (fe_cnt - fe0 + ov_cnt - ov0 !== 0) begin fails++; $display("FAIL single_err: got %0d expected 0", fe_cnt - fe0 + ov_cnt - ov0); end
    tests++;
    if ((rise_cyc - p) < 2063 || (rise_cyc - p) > 2065) begin
      fails++; $display("FAIL single_latency: got %0d expected 2064 +/-1", rise_cyc - p);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    urx_ready = 1'b1;
    base = got_q.size();
    send_byte(8'h48, 1'b1);
    send_byte(8'h65, 1'b1);
    send_byte(8'h6C, 1'b1);
    idle(20);
    tests++; if (got_q.size() !== base + 3) begin fails++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), base + 3); end
    tests++; if (got_at(base) !== 8'h48) begin fails++; $display("FAIL b2b_data0: got %h expected 48", got_at(base)); end
    tests++; if (got_at(base + 1) !== 8'h65) begin fails++; $display("FAIL b2b_data1: got %h expected 65", got_at(base + 1)); end
    tests++; if (got_at(base + 2) !== 8'h6C) begin fails++; $display("FAIL b2b_data2: got %h expected 6c", got_at(base + 2)); end
  endtask

  task automatic test_overrun();
    int base, ov0;
    urx_ready = 1'b0;
    base = got_q.size(); ov0 = ov_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);
    idle(20);
    tests++; if (ov_cnt - ov0 !== 1) begin fails++; $display("FAIL ovr_pulses: got %0d expected 1", ov_cnt - ov0); end
    tests++; if (urx_data !== 8'hA5) begin fails++; $display("FAIL ovr_data_held: got %h expected a5", urx_data); end
    tests++; if (urx_valid !== 1'b1) begin fails++; $display("FAIL ovr_valid_held: got %b expected 1", urx_valid); end
    tests++; if (got_q.size() !== base) begin fails++; $display("FAIL ovr_no_xfer: got %0d expected %0d", got_q.size(), base); end
    urx_ready = 1'b1;
    idle(5);
    tests++; if (got_q.size() !== base + 1) begin fails++; $display("FAIL ovr_drain_count: got %0d expected %0d", got_q.size(), base + 1); end
    tests++; if (got_at(base) !== 8'hA5) begin fails++; $display("FAIL ovr_drain_data: got %h expected a5", got_at(base)); end
    tests++; if (urx_valid !== 1'b0) begin fails++; $display("FAIL ovr_valid_drop: got %b expected 0", urx_valid); end
    urx_ready = 1'b0;
  endtask

  task automatic test_ready_on_delivery();
    int base, ov0;
    urx_ready = 1'b0;
    send_byte(8'hA5, 1'b1);
    idle(10);
    base = got_q.size(); ov0 = ov_cnt;
    fork
      send_byte(8'h3C, 1'b1);
      begin
        idle(2063);
        urx_ready = 1'b1;
        tick();
        urx_ready = 1'b0;
      end
    join
    idle(5);
    tests++; if (got_q.size() !== base + 1) begin fails++; $display("FAIL rod_count: got %0d expected %0d", got_q.size(), base + 1); end
    tests++; if (got_at(base) !== 8'hA5) begin fails++; $display("FAIL rod_xfer_data: got %h expected a5", got_at(base)); end
    tests++; if (urx_data !== 8'h3C) begin fails++; $display("FAIL rod_new_data: got %h expected 3c", urx_data); end
    tests++; if (urx_valid !== 1'b1) begin fails++; $display("FAIL rod_valid: got %b expected 1", urx_valid); end
    tests++; if (ov_cnt - ov0 !== 0) begin fails++; $display("FAIL rod_overrun: got %0d expected 0", ov_cnt - ov0); end
    urx_ready = 1'b1;
    idle(3);
  endtask

  task automatic test_frame_err();
    int base, fe0, ov0;
    urx_ready = 1'b1;
    base = got_q.size(); fe0 = fe_cnt; ov0 = ov_cnt;
    send_byte(8'h81, 1'b0);
    idle(20 * BIT);
    urx_pin = 1'b1;
    idle(2 * BIT);
    send_byte(8'h7E, 1'b1);
    idle(20);
    tests++; if (fe_cnt - fe0 !== 1) begin fails++; $display("FAIL fe_pulses: got %0d expected 1", fe_cnt - fe0); end
    tests++; if (got_q.size() !== base + 1) begin fails++; $display("FAIL fe_count: got %0d expected %0d", got_q.size(), base + 1); end
    tests++; if (got_at(base) !== 8'h7E) begin fails++; $display("FAIL fe_next_data: got %h expected 7e", got_at(base)); end
    tests++; if (ov_cnt - ov0 !== 0) begin fails++; $display("FAIL fe_overrun: got %0d expected 0", ov_cnt - ov0); end
  endtask

  task automatic test_glitch_reset();
    int base, fe0;
    urx_ready = 1'b1;
    base = got_q.size(); fe0 = fe_cnt;
    urx_pin = 1'b0;
    idle(50);
    urx_pin = 1'b1;
    idle(300);
    tests++; if (got_q.size() !== base) begin fails++; $display("FAIL glitch_no_byte: got %0d expected %0d", got_q.size(), base); end
    tests++; if (fe_cnt - fe0 !== 0) begin fails++; $display("FAIL glitch_no_err: got %0d expected 0", fe_cnt - fe0); end
    fork
      send_byte(8'hFF, 1'b1);
      begin
        idle(1000);
        rst = 1'b1;
        idle(2);
        tests++; if (urx_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid: got %b expected 0", urx_valid); end
        tests++; if (urx_data !== 8'h00) begin fails++; $display("FAIL rst_mid_data: got %h expected 00", urx_data); end
        tests++; if ((urx_frame_err | urx_overrun) !== 1'b0) begin fails++; $display("FAIL rst_mid_err: got %b expected 0", urx_frame_err | urx_overrun); end
        rst = 1'b0;
      end
    join
    idle(20);
    send_byte(8'h12, 1'b1);
    idle(20);
    tests++; if (got_q.size() !== base + 1) begin fails++; $display("FAIL rst_after_count: got %0d expected %0d", got_q.size(), base + 1); end
    tests++; if (got_at(base) !== 8'h12) begin fails++; $display("FAIL rst_after_data: got %h expected 12", got_at(base)); end
    tests++; if (fe_cnt - fe0 !== 0) begin fails++; $display("FAIL rst_after_err: got %0d expected 0", fe_cnt - fe0); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_ready_on_delivery();
    test_frame_err();
    test_glitch_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
